// File: rtl/alu_pkg.sv
// Shared encodings for the shared-ALU request controller.
// Op codes, FSM states and default widths live here.
package alu_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int OP_W_DEF   = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_MUL = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
// The priority pointer moves to the loser after every accepted grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;
    logic ptr_d;

    // Grant: a lone request wins; a tie goes to the pointed requester
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = ptr_q ? 2'b10 : 2'b01;
        end
    end

    // Next pointer: favour the requester that was not just served
    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            ptr_d = gnt_o[0];
        end
    end

    // Pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters.
// One operation at a time: accept, execute, hold the response.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [OP_W-1:0]     req0_op,
    input  logic [DATA_W-1:0]   req0_a,
    input  logic [DATA_W-1:0]   req0_b,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [OP_W-1:0]     req1_op,
    input  logic [DATA_W-1:0]   req1_a,
    input  logic [DATA_W-1:0]   req1_b,
    output logic                rsp0_valid,
    output logic                rsp1_valid,
    input  logic                rsp_ready,
    output logic [2*DATA_W-1:0] rsp_data,
    output logic                rsp_err,
    output logic [DATA_W-1:0]   alu_in1,
    output logic [DATA_W-1:0]   alu_in2,
    output logic [OP_W-1:0]     alu_con_sig,
    input  logic [2*DATA_W-1:0] alu_out
);

    state_e              state_q, state_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                id_q, id_d;
    logic [2*DATA_W-1:0] data_q, data_d;
    logic                err_q, err_d;

    logic [1:0] gnt;
    logic       idle;
    logic       hs;
    logic       illegal;

    assign idle    = (state_q == ST_IDLE);
    assign hs      = idle && (gnt != 2'b00);
    assign illegal = (op_q > OP_W'(OP_SRL));

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i ({req1_valid, req0_valid}),
        .adv_i (hs),
        .gnt_o (gnt)
    );

    // Next state: capture request, capture ALU result, wait for consumer
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    id_d    = gnt[1];
                    op_d    = gnt[1] ? req1_op : req0_op;
                    a_d     = gnt[1] ? req1_a : req0_a;
                    b_d     = gnt[1] ? req1_b : req0_b;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                data_d  = illegal ? '0 : alu_out;
                err_d   = illegal;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Handshake, response and ALU-facing outputs
    always_comb begin
        req0_ready  = idle && gnt[0] && !rst;
        req1_ready  = idle && gnt[1] && !rst;
        rsp0_valid  = (state_q == ST_RESP) && !id_q;
        rsp1_valid  = (state_q == ST_RESP) && id_q;
        rsp_data    = data_q;
        rsp_err     = err_q;
        alu_in1     = '0;
        alu_in2     = '0;
        alu_con_sig = '0;
        if (state_q == ST_EXEC) begin
            alu_in1 = a_q;
            alu_in2 = b_q;
            if (!illegal) begin
                alu_con_sig = op_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural ALU.
// Each task drives one scenario and checks inline.
module tb_alu_share_ctrl;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0;
    logic          req0_ready;
    logic [2:0]    req0_op = '0;
    logic [W-1:0]  req0_a = '0;
    logic [W-1:0]  req0_b = '0;
    logic          req1_valid = 1'b0;
    logic          req1_ready;
    logic [2:0]    req1_op = '0;
    logic [W-1:0]  req1_a = '0;
    logic [W-1:0]  req1_b = '0;
    logic          rsp0_valid;
    logic          rsp1_valid;
    logic          rsp_ready = 1'b0;
    logic [2*W-1:0] rsp_data;
    logic          rsp_err;
    logic [W-1:0]  alu_in1;
    logic [W-1:0]  alu_in2;
    logic [2:0]    alu_con_sig;
    logic [2*W-1:0] alu_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Reference ALU on the shared port
    always_comb begin
        alu_out = '0;
        case (alu_con_sig)
            3'd0: alu_out = {{W{1'b0}}, alu_in1} + {{W{1'b0}}, alu_in2};
            3'd1: alu_out = {{W{1'b0}}, alu_in1} * {{W{1'b0}}, alu_in2};
            3'd2: alu_out = {{W{1'b0}}, alu_in1 & alu_in2};
            3'd3: alu_out = {{W{1'b0}}, alu_in1 | alu_in2};
            3'd4: alu_out = {{W{1'b0}}, alu_in1} << alu_in2;
            3'd5: alu_out = {{W{1'b0}}, alu_in1} >> alu_in2;
            default: alu_out = '0;
        endcase
    end

    alu_share_ctrl #(.DATA_W(W), .OP_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_op     (req0_op),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_op     (req1_op),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .rsp0_valid  (rsp0_valid),
        .rsp1_valid  (rsp1_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_con_sig (alu_con_sig),
        .alu_out     (alu_out)
    );

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        logic [82:0] v;
        rst = 1'b1;
        req0_valid = 1'b1;
        @(negedge clk);
        v = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err,
             alu_con_sig, alu_in1, alu_in2, rsp_data};
        n_cmp++;
        if (v !== '0) begin
            n_bad++;
            $display("FAIL reset_outs: got %h want 0", v);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (req0_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_first_ready: got %b want 1", req0_ready);
        end
        req0_valid = 1'b0;
    endtask

    task automatic test_add;
        do_reset();
        req0_valid = 1'b1;
        req0_op = 3'd0;
        req0_a = 16'd3;
        req0_b = 16'd4;
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL add_ready: got %b want 01", {req1_ready, req0_ready});
        end
        @(negedge clk);
        req0_valid = 1'b0;
        n_cmp++;
        if ({alu_in1, alu_in2, alu_con_sig, rsp0_valid} !== {16'd3, 16'd4, 3'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL add_exec: in1 %h in2 %h op %h v %b want 3 4 0 0",
                     alu_in1, alu_in2, alu_con_sig, rsp0_valid);
        end
        @(negedge clk);
        n_cmp++;
        if ({rsp1_valid, rsp0_valid, rsp_err} !== 3'b010 || rsp_data !== 32'd7) begin
            n_bad++;
            $display("FAIL add_resp: v %b%b err %b data %h want 01 0 7",
                     rsp1_valid, rsp0_valid, rsp_err, rsp_data);
        end
        @(negedge clk);
        n_cmp++;
        if ({rsp0_valid, alu_in1, alu_con_sig} !== '0) begin
            n_bad++;
            $display("FAIL add_idle: v %b in1 %h want 0 0", rsp0_valid, alu_in1);
        end
    endtask

    task automatic test_round_robin;
        logic [1:0]  exp_rdy [7];
        logic [1:0]  exp_rv  [7];
        logic [31:0] exp_d   [7];
        exp_rdy = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01};
        exp_rv  = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00};
        exp_d   = '{32'h0, 32'h0, 32'hFFFE0001, 32'h0, 32'h0, 32'h00000FF0, 32'h0};
        do_reset();
        req0_valid = 1'b1;
        req0_op = 3'd1;
        req0_a = 16'hFFFF;
        req0_b = 16'hFFFF;
        req1_valid = 1'b1;
        req1_op = 3'd3;
        req1_a = 16'h00F0;
        req1_b = 16'h0F00;
        rsp_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            n_cmp++;
            if ({req1_ready, req0_ready} !== exp_rdy[k] ||
                {rsp1_valid, rsp0_valid} !== exp_rv[k]) begin
                n_bad++;
                $display("FAIL rr_step%0d: rdy %b rv %b want %b %b", k,
                         {req1_ready, req0_ready}, {rsp1_valid, rsp0_valid},
                         exp_rdy[k], exp_rv[k]);
            end
            if (exp_rv[k] != 2'b00) begin
                n_cmp++;
                if (rsp_data !== exp_d[k]) begin
                    n_bad++;
                    $display("FAIL rr_data%0d: got %h want %h", k, rsp_data, exp_d[k]);
                end
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_hold;
        do_reset();
        req1_valid = 1'b1;
        req1_op = 3'd4;
        req1_a = 16'd1;
        req1_b = 16'd15;
        rsp_ready = 1'b0;
        #1;
        n_cmp++;
        if (req1_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_ready: got %b want 1", req1_ready);
        end
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({rsp1_valid, rsp0_valid, req1_ready, req0_ready} !== 4'b1000 ||
                rsp_data !== 32'h00008000) begin
                n_bad++;
                $display("FAIL hold_cyc%0d: v %b%b rdy %b%b data %h want 10 00 8000", i,
                         rsp1_valid, rsp0_valid, req1_ready, req0_ready, rsp_data);
            end
        end
        rsp_ready = 1'b1;
        req1_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rsp1_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_release: got %b want 0", rsp1_valid);
        end
    endtask

    task automatic test_illegal;
        do_reset();
        req0_valid = 1'b1;
        req0_op = 3'd7;
        req0_a = 16'd5;
        req0_b = 16'd6;
        rsp_ready = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        n_cmp++;
        if (alu_con_sig !== 3'd0) begin
            n_bad++;
            $display("FAIL illegal_op: got %h want 0", alu_con_sig);
        end
        @(negedge clk);
        n_cmp++;
        if ({rsp0_valid, rsp_err} !== 2'b11 || rsp_data !== 32'd0) begin
            n_bad++;
            $display("FAIL illegal_resp: v %b err %b data %h want 1 1 0",
                     rsp0_valid, rsp_err, rsp_data);
        end
    endtask

    task automatic test_reset_exec;
        logic [82:0] v;
        do_reset();
        req0_valid = 1'b1;
        req0_op = 3'd0;
        req0_a = 16'd9;
        req0_b = 16'd1;
        rsp_ready = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        rst = 1'b1;
        #1;
        v = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err,
             alu_con_sig, alu_in1, alu_in2, rsp_data};
        n_cmp++;
        if (v !== '0) begin
            n_bad++;
            $display("FAIL rstexec_outs: got %h want 0", v);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({rsp1_valid, rsp0_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL rstexec_norsp: got %b want 00", {rsp1_valid, rsp0_valid});
        end
        req1_valid = 1'b1;
        req1_op = 3'd2;
        req1_a = 16'h00FF;
        req1_b = 16'h0F0F;
        #1;
        n_cmp++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            n_bad++;
            $display("FAIL rstexec_rdy1: got %b want 10", {req1_ready, req0_ready});
        end
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({rsp1_valid, rsp0_valid} !== 2'b10 || rsp_data !== 32'h0000000F) begin
            n_bad++;
            $display("FAIL rstexec_rsp1: v %b data %h want 10 0000000f",
                     {rsp1_valid, rsp0_valid}, rsp_data);
        end
        @(negedge clk);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        n_cmp++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL rstexec_ptr: got %b want 01", {req1_ready, req0_ready});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_srl_stable;
        do_reset();
        req0_valid = 1'b1;
        req0_op = 3'd5;
        req0_a = 16'h8000;
        req0_b = 16'd3;
        rsp_ready = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        req0_op = 3'd0;
        req0_a = 16'hFFFF;
        req0_b = 16'd0;
        #1;
        n_cmp++;
        if ({alu_in1, alu_in2, alu_con_sig} !== {16'h8000, 16'd3, 3'd5}) begin
            n_bad++;
            $display("FAIL srl_exec: in1 %h in2 %h op %h want 8000 3 5",
                     alu_in1, alu_in2, alu_con_sig);
        end
        @(negedge clk);
        n_cmp++;
        if (rsp0_valid !== 1'b1 || rsp_data !== 32'h00001000) begin
            n_bad++;
            $display("FAIL srl_resp: v %b data %h want 1 00001000", rsp0_valid, rsp_data);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_round_robin();
        test_hold();
        test_illegal();
        test_reset_exec();
        test_srl_stable();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
ALU_SHARE_CTRL -- requirements
Module: alu_share_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning operand width.
REQ-002 The block SHALL have parameter OP_W, default 3, meaning ALU op-select width.
REQ-003 The block SHALL have port clk  input  1  single clock, rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have ports reqN_valid  input  1  request N (N=0,1) valid.
REQ-006 The block SHALL have ports reqN_ready  output  1  request N accepted this cycle when valid.
REQ-007 The block SHALL have ports reqN_op  input  OP_W  operation (000 add, 001 mul, 010 and, 011 or, 100 sll, 101 srl).
REQ-008 The block SHALL have ports reqN_a, reqN_b  input  DATA_W  operands.
REQ-009 The block SHALL have ports rspN_valid  output  1  result for requester N available.
REQ-010 The block SHALL have port rsp_ready  input  1  result consumer accepts the response.
REQ-011 The block SHALL have port rsp_data  output  2*DATA_W  result.
REQ-012 The block SHALL have port rsp_err  output  1  illegal op flagged (110/111).
REQ-013 The block SHALL have ports alu_in1, alu_in2  output  DATA_W  and alu_con_sig  output  OP_W  to the shared ALU.
REQ-014 The block SHALL have port alu_out  input  2*DATA_W  ALU result (combinational ALU).

Function
REQ-015 FSM states SHALL be IDLE, EXEC, RESP.
REQ-016 In IDLE, ready SHALL be asserted only to the granted requester; no ready in EXEC or RESP.
REQ-017 Arbitration SHALL be round-robin: single valid wins; both valid -> requester indicated by priority pointer wins; pointer flips to the other requester after each grant; pointer resets to 0.
REQ-018 On handshake (valid && ready) the op, operands and requester id SHALL be registered; IDLE -> EXEC.
REQ-019 In EXEC, alu_in1/alu_in2/alu_con_sig SHALL be driven from registers; alu_out captured into rsp_data at end of cycle; EXEC -> RESP.
REQ-020 Illegal op (110/111) SHALL not be issued to ALU: alu_con_sig driven 000, rsp_data captured as 0, rsp_err 1.
REQ-021 In RESP, rspN_valid SHALL be asserted for the captured requester id only; rsp_data/rsp_err stable until rsp_ready.
REQ-022 RESP with rsp_ready SHALL return to IDLE; new requests accepted next cycle (one op per 3 cycles minimum).
REQ-023 Latency: handshake cycle N -> rspN_valid asserted cycle N+2.
REQ-024 Outside EXEC, ALU-facing outputs SHALL be 0.
REQ-025 rsp_ready while not in RESP SHALL be ignored.
REQ-026 Requester changing op/operands after handshake SHALL not affect in-flight result.

Reset
REQ-027 rst assertion SHALL force IDLE immediately, clearing state, pointer, registered operands, rsp_data, rsp_err, all valid/ready outputs and ALU outputs to 0.
REQ-028 Reset mid-EXEC or mid-RESP SHALL discard the in-flight operation; no response issued.
REQ-029 First handshake possible on first clk edge after rst deasserts.

Structure
REQ-030 Op encodings (OP_ADD..OP_SRL), FSM state encoding and widths SHALL live in shared package alu_pkg.
REQ-031 Round-robin grant logic SHALL be sub-module rr_arb2 (2 requests, pointer, grant); remainder flat.

Verification
REQ-032 req0 add a=3 b=4 alone, rsp_ready=1 -> rsp0_valid at N+2, rsp_data=7, rsp_err=0.
REQ-033 Both valid every cycle, req0 mul 0xFFFF*0xFFFF, req1 or 0x00F0|0x0F00 -> grants alternate 0,1,0; data 0xFFFE0001 and 0x00000FF0.
REQ-034 req1 sll a=1 b=15, rsp_ready held 0 five cycles -> rsp1_valid and rsp_data=0x00008000 stable, reqN_ready 0 throughout.
REQ-035 req0 op=111 -> alu_con_sig 000, rsp_data=0, rsp_err=1.
REQ-036 rst pulsed in EXEC of req0 and add -> no rsp valid, all outputs 0, next req1 request served with pointer 0 rules.
REQ-037 req0 srl a=0x8000 b=3, operands changed after handshake -> rsp_data=0x00001000.
